// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port ram32: round-robin with lock,
// zero-latency grant, read-return routing and a saturating contention counter.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-3:0] m0_addr,
    input  logic [31:0]           m0_din,
    input  logic [3:0]            m0_bwe,
    input  logic                  m0_lock,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [31:0]           m0_rdata,

    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-3:0] m1_addr,
    input  logic [31:0]           m1_din,
    input  logic [3:0]            m1_bwe,
    input  logic                  m1_lock,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [31:0]           m1_rdata,

    output logic [ADDR_WIDTH-3:0] ram_addr,
    output logic [31:0]           ram_din,
    output logic [3:0]            ram_bwe,
    output logic                  ram_ren,
    input  logic [31:0]           ram_dout,

    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    logic                 last_grant;
    logic                 lock_active;
    logic                 lock_owner;
    logic                 rd_pending;
    logic                 rd_owner;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic                 gnt0;
    logic                 gnt1;
    logic                 granted;
    logic [3:0]           sel_bwe;
    logic                 sel_lock;
    logic                 deny;

    // Lock beats everything; a tie goes to whoever did not win last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (resetn) begin
            if (lock_active) begin
                gnt0 = m0_req & ~lock_owner;
                gnt1 = m1_req &  lock_owner;
            end else if (m0_req && m1_req) begin
                gnt0 =  last_grant;
                gnt1 = ~last_grant;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    always_comb begin
        granted  = gnt0 | gnt1;
        sel_bwe  = gnt1 ? m1_bwe  : m0_bwe;
        sel_lock = gnt1 ? m1_lock : m0_lock;
        ram_addr = gnt1 ? m1_addr : m0_addr;
        ram_din  = gnt1 ? m1_din  : m0_din;
        ram_bwe  = granted ? sel_bwe : 4'b0000;
        ram_ren  = granted & (sel_bwe == 4'b0000);
        deny     = (m0_req & ~gnt0) | (m1_req & ~gnt1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant  <= 1'b1;
            lock_active <= 1'b0;
            lock_owner  <= 1'b0;
            rd_pending  <= 1'b0;
            rd_owner    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (granted) begin
                last_grant  <= gnt1;
                lock_active <= sel_lock;
                lock_owner  <= gnt1;
            end
            rd_pending <= ram_ren;
            if (ram_ren) begin
                rd_owner <= gnt1;
            end
            if (deny && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign m0_gnt       = gnt0;
    assign m1_gnt       = gnt1;
    // Gate with resetn so a read caught by reset never pulses rvalid.
    assign m0_rvalid    = resetn & rd_pending & ~rd_owner;
    assign m1_rvalid    = resetn & rd_pending &  rd_owner;
    assign m0_rdata     = ram_dout;
    assign m1_rdata     = ram_dout;
    assign conflict_cnt = cnt_q;

endmodule
